spi_scheduler: RTL and testbench

SPI_SCHEDULER -- requirements
Module: spi_scheduler

---
 rtl/spi_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/spi_scheduler.sv | 178 +++++++++++++++++
 tb/tb_spi_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI request scheduler: word width, timeout default, FSM states.
package spi_pkg;

  localparam int unsigned WordW = 32;
  localparam logic [15:0] TimeoutDefault = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StTrig,
    StWaitLo,
    StWaitHi,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first asserted request at or after ptr+1 (mod NREQ).
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Scan NREQ positions starting just after the last winner; first hit wins.
  always_comb begin
    int unsigned j;
    logic [IdxW-1:0] jj;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    jj      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j  = (32'(ptr_i) + k) % NREQ;
      jj = IdxW'(j);
      if (!valid_o && req_i[jj]) begin
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
        valid_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_scheduler.sv
// Shares one SPI master among NREQ requesters: round-robin grant, trigger strobe,
// slave-select handshake with timeout, and per-requester completion pulses.
module spi_scheduler
  import spi_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TRIG_CYC = 4,
  parameter logic [15:0] TIMEOUT  = TimeoutDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NREQ-1:0]       req,
  input  logic [WordW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [WordW-1:0]      rx_data,
  output logic                  spi_en,
  output logic                  spi_trig,
  output logic [WordW-1:0]      spi_data32,
  input  logic                  spi_ssel,
  input  logic [WordW-1:0]      spi_rx_data
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [WordW-1:0]  data_q, data_d;
  logic [WordW-1:0]  rx_q, rx_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [15:0]       trig_cnt_q, trig_cnt_d;
  logic              spi_en_q, spi_en_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_valid;
  logic [WordW-1:0]  words [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = req_data[i*WordW +: WordW];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Next-state logic; en low overrides everything and returns to idle with the master disabled.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    gnt_oh_d   = gnt_oh_q;
    data_d     = data_q;
    rx_d       = rx_q;
    wait_cnt_d = wait_cnt_q;
    trig_cnt_d = trig_cnt_q;
    spi_en_d   = spi_en_q;
    if (!en) begin
      state_d  = StIdle;
      spi_en_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_d  = StArb;
            spi_en_d = 1'b1;
          end
        end
        StArb: begin
          // Requests may vanish between IDLE and ARB; fall back rather than grant nobody.
          if (arb_valid) begin
            idx_d      = arb_idx;
            gnt_oh_d   = arb_gnt;
            data_d     = words[arb_idx];
            trig_cnt_d = '0;
            state_d    = StTrig;
          end else begin
            state_d = StIdle;
          end
        end
        StTrig: begin
          if (trig_cnt_q == 16'(TRIG_CYC - 1)) begin
            wait_cnt_d = '0;
            state_d    = StWaitLo;
          end else begin
            trig_cnt_d = trig_cnt_q + 16'd1;
          end
        end
        StWaitLo: begin
          if (!spi_ssel) begin
            wait_cnt_d = '0;
            state_d    = StWaitHi;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            if (wait_cnt_d == TIMEOUT) state_d = StErr;
          end
        end
        StWaitHi: begin
          // Capture on the way into DONE so rx_data is valid alongside the done pulse.
          if (spi_ssel) begin
            rx_d    = spi_rx_data;
            state_d = StDone;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            if (wait_cnt_d == TIMEOUT) state_d = StErr;
          end
        end
        StDone: begin
          ptr_d   = idx_q;
          state_d = StIdle;
        end
        StErr: begin
          ptr_d   = idx_q;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= IdxW'(NREQ - 1);
      idx_q      <= '0;
      gnt_oh_q   <= '0;
      data_q     <= '0;
      rx_q       <= '0;
      wait_cnt_q <= '0;
      trig_cnt_q <= '0;
      spi_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      gnt_oh_q   <= gnt_oh_d;
      data_q     <= data_d;
      rx_q       <= rx_d;
      wait_cnt_q <= wait_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      spi_en_q   <= spi_en_d;
    end
  end

  // Outputs decoded from the registered state so reset clears them immediately.
  always_comb begin
    gnt  = '0;
    done = '0;
    unique case (state_q)
      StArb:                              gnt = arb_gnt;
      StTrig, StWaitLo, StWaitHi:         gnt = gnt_oh_q;
      StDone, StErr: begin
        gnt  = gnt_oh_q;
        done = gnt_oh_q;
      end
      default: gnt = '0;
    endcase
  end

  assign err        = (state_q == StErr);
  assign spi_trig   = (state_q == StTrig);
  assign spi_en     = spi_en_q;
  assign rx_data    = rx_q;
  assign spi_data32 = data_q;

endmodule

// File: tb/tb_spi_scheduler.sv
// Scoreboard bench for spi_scheduler with a behavioural SPI slave on the ssel/rx side.
module tb_spi_scheduler;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned TRIG_CYC = 4;
  localparam logic [15:0] TIMEOUT  = 16'd100;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [31:0]       rx_data;
  logic              spi_en;
  logic              spi_trig;
  logic [31:0]       spi_data32;
  logic              spi_ssel = 1'b1;
  logic [31:0]       spi_rx_data = '0;

  spi_scheduler #(
    .NREQ     (NREQ),
    .TRIG_CYC (TRIG_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .rx_data     (rx_data),
    .spi_en      (spi_en),
    .spi_trig    (spi_trig),
    .spi_data32  (spi_data32),
    .spi_ssel    (spi_ssel),
    .spi_rx_data (spi_rx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
    logic [31:0] rx;
    logic        is_err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  logic model_on = 1'b1;
  logic abort_expected = 1'b0;
  logic [31:0] exp_rx_last = '0;

  localparam logic [31:0] W0 = 32'h0000_1000;
  localparam logic [31:0] W1 = 32'h1111_0001;
  localparam logic [31:0] W2 = 32'h2222_0002;
  localparam logic [31:0] W3 = 32'h3333_0003;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input int unsigned idx, input logic [31:0] data, input logic is_err);
    exp_t e;
    e.idx    = idx;
    e.data   = data;
    e.is_err = is_err;
    e.rx     = is_err ? exp_rx_last : ~data;
    if (!is_err) exp_rx_last = ~data;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= target) break;
    end
    check_eq(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_ssel(input logic lvl, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi_ssel == lvl) break;
    end
    check_eq(tag, 32'(spi_ssel), 32'(lvl));
  endtask

  task automatic wait_trig(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi_trig) break;
    end
    check_eq(tag, 32'(spi_trig), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Slave model: ssel low 5 cycles after trig, high 40 later, returns the inverted tx word.
  always begin
    @(posedge spi_trig);
    if (model_on) begin
      repeat (5) @(negedge clk);
      spi_rx_data = ~spi_data32;
      spi_ssel    = 1'b0;
      repeat (40) @(negedge clk);
      spi_ssel    = 1'b1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on each done pulse and tracks trig timing.
  logic trig_prev = 1'b0;
  logic have_rise = 1'b0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   trig_len = 0;
  always @(negedge clk) begin
    if (reset) begin
      trig_prev = 1'b0;
      have_rise = 1'b0;
      trig_len  = 0;
    end else begin
      if (done !== '0) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check_eq("done_unexpected", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("done_onehot", 32'(done), 32'd1 << e.idx);
          check_eq("gnt_at_done", 32'(gnt), 32'd1 << e.idx);
          check_eq("err_flag", 32'(err), 32'(e.is_err));
          check_eq("rx_data", rx_data, e.rx);
          check_eq("tx_word", spi_data32, e.data);
          if (e.is_err) check_eq("err_latency", 32'(cyc - fall_cyc), 32'(TIMEOUT));
        end
      end else if (err) begin
        check_eq("err_without_done", 32'(err), 32'd0);
      end
      if (spi_trig && !trig_prev) begin
        if (have_rise) check_eq("trig_spacing_ok", 32'(cyc - rise_cyc >= int'(TRIG_CYC) + 4), 32'd1);
        rise_cyc  = cyc;
        have_rise = 1'b1;
        trig_len  = 0;
      end
      if (spi_trig) trig_len++;
      if (!spi_trig && trig_prev) begin
        fall_cyc = cyc;
        if (!abort_expected) check_eq("trig_len", 32'(trig_len), 32'(TRIG_CYC));
      end
      trig_prev = spi_trig;
    end
  end

  int base;

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    req      = '0;
    req_data = {W3, W2, W1, 32'hA5A5_0001};
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rx", rx_data, 32'd0);
    check_eq("rst_tx", spi_data32, 32'd0);
    check_eq("rst_trig", 32'(spi_trig), 32'd0);
    check_eq("rst_spi_en", 32'(spi_en), 32'd0);
    reset = 1'b0;

    // Single request from requester 0.
    @(negedge clk);
    push_exp(0, 32'hA5A5_0001, 1'b0);
    req = 4'b0001;
    wait_done(1, 200, "single_done");
    req = '0;
    repeat (3) @(negedge clk);
    check_eq("single_one_done", 32'(done_cnt), 32'd1);

    // All four requesting continuously from reset: order 0,1,2,3,0.
    do_reset();
    exp_rx_last = '0;
    req_data = {W3, W2, W1, W0};
    push_exp(0, W0, 1'b0);
    push_exp(1, W1, 1'b0);
    push_exp(2, W2, 1'b0);
    push_exp(3, W3, 1'b0);
    push_exp(0, W0, 1'b0);
    base = done_cnt;
    req = 4'b1111;
    wait_done(base + 5, 800, "rr_done");
    req = '0;
    repeat (3) @(negedge clk);
    check_eq("rr_count", 32'(done_cnt - base), 32'd5);

    // Timeout: slave never answers; ptr=0 so requester 2 wins.
    model_on = 1'b0;
    push_exp(2, W2, 1'b1);
    base = done_cnt;
    req = 4'b0100;
    wait_done(base + 1, 300, "timeout_done");
    req = '0;
    repeat (3) @(negedge clk);
    model_on = 1'b1;

    // Reset in WAIT_HI: outputs clear at once, no done, then requester 2 wins first.
    base = done_cnt;
    req = 4'b0001;
    wait_ssel(1'b0, 100, "rst_mid_ssel_lo");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rstmid_gnt", 32'(gnt), 32'd0);
    check_eq("rstmid_done", 32'(done), 32'd0);
    check_eq("rstmid_trig", 32'(spi_trig), 32'd0);
    check_eq("rstmid_spi_en", 32'(spi_en), 32'd0);
    check_eq("rstmid_tx", spi_data32, 32'd0);
    check_eq("rstmid_rx", rx_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    exp_rx_last = '0;
    wait_ssel(1'b1, 100, "rst_mid_ssel_hi");
    check_eq("rstmid_no_done", 32'(done_cnt - base), 32'd0);
    push_exp(2, W2, 1'b0);
    req = 4'b0100;
    wait_ssel(1'b0, 100, "post_rst_ssel_lo");
    check_eq("post_rst_gnt", 32'(gnt), 32'b0100);
    wait_done(base + 1, 200, "post_rst_done");
    req = '0;
    repeat (3) @(negedge clk);

    // en dropped during TRIG: trig and gnt drop next cycle, no done or err.
    base = done_cnt;
    req = 4'b0010;
    wait_trig(50, "abort_trig_seen");
    abort_expected = 1'b1;
    en = 1'b0;
    @(negedge clk);
    check_eq("abort_trig", 32'(spi_trig), 32'd0);
    check_eq("abort_gnt", 32'(gnt), 32'd0);
    check_eq("abort_spi_en", 32'(spi_en), 32'd0);
    req = '0;
    wait_ssel(1'b0, 100, "abort_model_lo");
    wait_ssel(1'b1, 100, "abort_model_hi");
    check_eq("abort_no_done", 32'(done_cnt - base), 32'd0);
    en = 1'b1;
    abort_expected = 1'b0;
    repeat (2) @(negedge clk);

    // req[1] dropped during WAIT_HI still completes.
    base = done_cnt;
    push_exp(1, W1, 1'b0);
    req = 4'b0010;
    wait_ssel(1'b0, 100, "drop_ssel_lo");
    repeat (2) @(negedge clk);
    req = '0;
    wait_done(base + 1, 200, "drop_done");
    repeat (3) @(negedge clk);

    // Fairness: ptr=1, requesters 0 and 1 held -> 0, 1, 0.
    base = done_cnt;
    push_exp(0, W0, 1'b0);
    push_exp(1, W1, 1'b0);
    push_exp(0, W0, 1'b0);
    req = 4'b0011;
    wait_done(base + 3, 500, "fair_done");
    req = '0;
    repeat (3) @(negedge clk);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
